// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word address and
// fills the IF/ID register, handling stalls, redirects with a one-bubble penalty, and halt.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic [IMEM_AW-1:0] inst_addr,
  input  logic [31:0]        inst_data,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_inst,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // Redirect outranks stall so a resolved branch is never lost.
        if (redirect) begin
          pc_d          = redirect_pc & 32'hFFFF_FFFC;
          if_id_inst_d  = 32'h0;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          if_id_inst_d  = inst_data;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_q + 32'd4;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
        if (halt_req) state_d = StHalt;
      end
      default: state_d = state_q;
    endcase
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_inst_q  <= 32'h0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign inst_addr   = pc_q[IMEM_AW+1:2];
  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, halt_req;
  logic [31:0] redirect_pc, inst_data;
  logic [7:0]  inst_addr;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_inst, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [256];

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  assign inst_data = mem[inst_addr];

  if_stage #(.RESET_PC(32'h0), .IMEM_AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_inst = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect) begin
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_inst  = 32'h0;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_inst  = mem[m_pc[9:2]];
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_cnt   = m_cnt + 32'd1;
      end
      if (halt_req) m_mode = 2;
    end
  endtask

  // One clock edge: advance the model, then compare every output shortly after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("pc", pc, m_pc);
    chk("inst_addr", {24'h0, inst_addr}, {24'h0, m_pc[9:2]});
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pc4", if_id_pc4, m_ipc4);
    chk("if_id_inst", if_id_inst, m_inst);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_mode == 2});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic idle();
    stall = 1'b0; redirect = 1'b0; halt_req = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h2001_0009; mem[2] = 32'h0000_1020;
    mem[4] = 32'h8c86_0000; mem[9] = 32'hace6_0000;
    m_mode = 0; m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_inst = 0; m_valid = 0; m_cnt = 0;
    idle();
    rst_n = 1'b0;
    step();
    do_reset();

    // Boot cycle then free-run.
    step();
    chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
    step(); chk("fetch0", if_id_inst, 32'hFFFF_FFFF); chk("fetch0_pc", if_id_pc, 32'h0);
    step(); chk("fetch1", if_id_inst, 32'h2001_0009); chk("fetch1_pc", if_id_pc, 32'h4);
    step(); chk("fetch2", if_id_inst, 32'h0000_1020); chk("fetch2_pc", if_id_pc, 32'h8);
    chk("pc_after3", pc, 32'h0C);
    chk("count_after3", fetch_count, 32'd3);
    step();

    // Stall at pc=0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", {24'h0, inst_addr}, 32'd4);
      chk("stall_pc", pc, 32'h10);
    end
    stall = 1'b0;
    step();
    chk("post_stall_inst", if_id_inst, 32'h8c86_0000);

    // Redirect to 0x24 from pc=0x20.
    for (int i = 0; i < 3; i++) step();
    chk("pre_redir_pc", pc, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h24;
    step();
    chk("redir_pc", pc, 32'h24);
    chk("redir_bubble", {31'h0, if_id_valid}, 32'h0);
    idle();
    step();
    chk("redir_target", if_id_inst, 32'hace6_0000);
    chk("redir_target_pc", if_id_pc, 32'h24);

    // Redirect together with stall, misaligned target.
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h07;
    step();
    chk("redir_stall_pc", pc, 32'h04);
    chk("redir_stall_bubble", if_id_inst, 32'h0);
    idle();
    for (int i = 0; i < 10; i++) step();

    // Mid-run reset, then halt at pc=0x14.
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("pre_halt_pc", pc, 32'h14);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_pc", pc, 32'h18);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      redirect = i[0]; redirect_pc = $urandom; stall = $urandom_range(0, 1);
      step();
    end
    chk("halt_frozen_pc", pc, 32'h18);
    idle();

    // Address wrap.
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h3FC;
    step();
    idle();
    chk("wrap_addr_hi", {24'h0, inst_addr}, 32'd255);
    step();
    chk("wrap_pc", pc, 32'h400);
    chk("wrap_addr_lo", {24'h0, inst_addr}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 40) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 6) == 0);
      redirect_pc = $urandom;
      halt_req    = ($urandom_range(0, 50) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline CPU.
- Owns the program counter and drives the word address of the instruction memory, which returns data combinationally in the same cycle.
- Registers the fetched word into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls, branch/jump redirects with bubble insertion, and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC by reset.
- IMEM_AW, 8, instruction-memory word-address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hazard unit: hold the PC and IF/ID.
- redirect  input  1  branch taken or jump resolved downstream.
- redirect_pc  input  32  byte target of the redirect.
- halt_req  input  1  request to enter HALT.
- inst_addr  output  IMEM_AW  word address to the instruction memory; equals pc[IMEM_AW+1:2].
- inst_data  input  32  instruction word from the instruction memory, same cycle.
- pc  output  32  current fetch PC (register).
- if_id_pc  output  32  PC of the instruction held in IF/ID.
- if_id_pc4  output  32  if_id_pc+4.
- if_id_inst  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  high in HALT.
- fetch_count  output  32  count of accepted fetches.

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values (applied on any edge with rst_n=0, including mid-operation; all other inputs are ignored that cycle):
  - pc=RESET_PC; if_id_pc=0; if_id_pc4=0; if_id_inst=0; if_id_valid=0; fetch_count=0; halted=0; state=BOOT.
- States:
  - BOOT: lasts exactly one cycle after reset is released. PC holds, IF/ID stays a bubble. Goes to RUN unconditionally; halt_req is ignored.
  - RUN: normal fetch; actions per edge, priority listed below.
  - HALT: PC, IF/ID and fetch_count all frozen; halted=1. Only reset exits HALT.
- RUN actions per edge, highest priority first:
  1. redirect=1: pc <= {redirect_pc[31:2],2'b00}; IF/ID becomes a bubble (inst=0, valid=0, if_id_pc/if_id_pc4 hold). Applies even when stall=1. fetch_count holds.
  2. stall=1: pc, all IF/ID outputs and fetch_count hold.
  3. Otherwise, an accepted fetch:
     - if_id_inst <= inst_data; if_id_pc <= pc; if_id_pc4 <= pc+4; if_id_valid <= 1.
     - pc <= pc+4; fetch_count <= fetch_count+1.
- halt_req:
  - In RUN it is sampled each edge. When high, the state becomes HALT at that edge; the current cycle's RUN action (redirect, stall or fetch) still completes.
  - It has no effect in BOOT or HALT.
- Latency: the instruction at pc appears on if_id_inst one edge after it is accepted. After a redirect, the first valid target instruction appears two edges after the redirect edge, giving a one-bubble penalty.
- Arithmetic:
  - pc+4 and fetch_count wrap modulo 2^32.
  - inst_addr wraps naturally at 2^IMEM_AW words, because pc bits above IMEM_AW+1 are not used for the address.
  - A misaligned redirect_pc has bits [1:0] cleared.
- inst_addr is purely combinational from the pc register: no extra latency, and it is stable through a stall.
- if_id_valid=0 marks a bubble. Decode must treat it as a NOP; in a bubble if_id_inst=0 (sll $0,$0,0).

Test Plan:
- Reset then free-run; instruction memory word0=0xFFFFFFFF, word1=0x20010009, word2=0x00001020:
  - BOOT cycle shows if_id_valid=0.
  - Following edges give if_id_inst 0xFFFFFFFF, 0x20010009, 0x00001020 with if_id_pc 0, 4, 8.
  - pc=0x0C; fetch_count=3.
- Stall held for 3 cycles while pc=0x10:
  - pc, inst_addr=4, IF/ID outputs and fetch_count unchanged for all 3 cycles.
  - Word 4 (0x8c860000) enters IF/ID on the first edge after stall drops.
- Redirect to 0x24 while pc=0x20:
  - Next edge: pc=0x24, if_id_valid=0, if_id_inst=0.
  - Following edge: if_id_inst=word 9 (0xace60000), if_id_pc=0x24.
- Redirect and stall asserted together, redirect_pc=0x07:
  - Redirect wins: pc=0x04 and a bubble is inserted.
- halt_req pulse in RUN with pc=0x14:
  - That edge completes the fetch (pc=0x18); halted=1.
  - Nothing changes for 10 further cycles even with redirect toggling.
- rst_n low for one edge mid-RUN (pc=0x30, fetch_count=12):
  - All outputs return to their reset values, then the BOOT/RUN sequence repeats.
- Wrap: force pc=0x3FC via redirect:
  - inst_addr=255; the next fetch gives pc=0x400 and inst_addr=0.
